rf_writeback: RTL

//  Writer side of the register file: drives its synchronous write port (wen/waddr/wdata).

---
 rtl/rf_writeback_pkg.sv | 39 +++
 rtl/rf_writeback_if.sv | 47 ++++
 rtl/rf_writeback_ld_fifo.sv | 34 +++
 rtl/rf_writeback.sv | 87 ++++++++
 4 files changed

// File: rtl/rf_writeback_pkg.sv
// rf_writeback_pkg: load funct3 codes, register-file widths, load entry type and load formatter.
package rf_writeback_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        off;
        logic [XLEN-1:0]   data;
    } ld_entry_t;
    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] data;
    } ld_fmt_t;
    // Unknown funct3 falls back to a full-word write but is flagged like a misalignment.
    function automatic ld_fmt_t fmt_load(ld_entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        ld_fmt_t     r;
        b = e.data[{e.off, 3'b000} +: 8];
        h = e.off[1] ? e.data[31:16] : e.data[15:0];
        r.err  = 1'b0;
        r.data = e.data;
        case (e.funct3)
            F3_LB:   r.data = {{24{b[7]}}, b};
            F3_LH:   begin r.data = {{16{h[15]}}, h}; r.err = e.off[0]; end
            F3_LW:   r.err = |e.off;
            F3_LBU:  r.data = {24'b0, b};
            F3_LHU:  begin r.data = {16'b0, h}; r.err = e.off[0]; end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/rf_writeback_if.sv
// rf_writeback_if: ALU/load/regfile-write bundle; optional WB_FWD_EN adds the operand bypass ports.
interface rf_writeback_if;
    import rf_writeback_pkg::*;
    logic              i_alu_valid;
    logic              o_alu_ready;
    logic [REG_AW-1:0] i_alu_rd_5;
    logic [XLEN-1:0]   i_alu_data_32;
    logic              i_ld_issue;
    logic [REG_AW-1:0] i_ld_issue_rd_5;
    logic              i_ld_valid;
    logic              o_ld_ready;
    logic [REG_AW-1:0] i_ld_rd_5;
    logic [XLEN-1:0]   i_ld_data_32;
    logic [2:0]        i_ld_funct3_3;
    logic [1:0]        i_ld_off_2;
    logic              o_wen;
    logic [REG_AW-1:0] o_waddr_5;
    logic [XLEN-1:0]   o_wdata_32;
    logic [XLEN-1:0]   o_busy_32;
    logic              o_misalign_err;
`ifdef WB_FWD_EN
    logic [REG_AW-1:0] i_raddr1_5;
    logic [REG_AW-1:0] i_raddr2_5;
    logic [XLEN-1:0]   i_rf_rdata1_32;
    logic [XLEN-1:0]   i_rf_rdata2_32;
    logic [XLEN-1:0]   o_opnd1_32;
    logic [XLEN-1:0]   o_opnd2_32;
`endif
    modport master (
        output i_alu_valid, i_alu_rd_5, i_alu_data_32, i_ld_issue, i_ld_issue_rd_5,
               i_ld_valid, i_ld_rd_5, i_ld_data_32, i_ld_funct3_3, i_ld_off_2,
        input  o_alu_ready, o_ld_ready, o_wen, o_waddr_5, o_wdata_32, o_busy_32, o_misalign_err
`ifdef WB_FWD_EN
        , output i_raddr1_5, i_raddr2_5, i_rf_rdata1_32, i_rf_rdata2_32
        , input  o_opnd1_32, o_opnd2_32
`endif
    );
    modport slave (
        input  i_alu_valid, i_alu_rd_5, i_alu_data_32, i_ld_issue, i_ld_issue_rd_5,
               i_ld_valid, i_ld_rd_5, i_ld_data_32, i_ld_funct3_3, i_ld_off_2,
        output o_alu_ready, o_ld_ready, o_wen, o_waddr_5, o_wdata_32, o_busy_32, o_misalign_err
`ifdef WB_FWD_EN
        , input  i_raddr1_5, i_raddr2_5, i_rf_rdata1_32, i_rf_rdata2_32
        , output o_opnd1_32, o_opnd2_32
`endif
    );
endinterface

// File: rtl/rf_writeback_ld_fifo.sv
// wb_ld_fifo: synchronous load-response FIFO; pointers carry an extra wrap bit to tell full from empty.
module wb_ld_fifo #(
    parameter int W = 42,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(D);
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic [W-1:0] r_mem [D];
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_head  = r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + (AW+1)'(1);
            if (i_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU results and buffered load responses into the regfile write port with a load scoreboard.
// Optional WB_FWD_EN adds a combinational bypass of the in-flight write onto two read operands.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    rf_writeback_if.slave bus
);
    ld_entry_t         w_head;
    ld_entry_t         w_push_entry;
    ld_fmt_t           w_fmt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_contend;
    logic              w_grant_ld;
    logic              w_grant_alu;
    logic [XLEN-1:0]   w_set;
    logic [XLEN-1:0]   w_clr;
    logic              r_rr_ld;
    logic              r_wen;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_busy;
    logic              r_err;
    assign w_push       = bus.i_ld_valid && !w_full;
    assign w_push_entry = {bus.i_ld_rd_5, bus.i_ld_funct3_3, bus.i_ld_off_2, bus.i_ld_data_32};
    wb_ld_fifo #(.W($bits(ld_entry_t)), .D(LD_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_grant_ld),
        .i_din   (w_push_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );
    // r_rr_ld names the source that wins the next contended cycle.
    assign w_contend   = !w_empty && bus.i_alu_valid;
    assign w_grant_ld  = !w_empty && (!bus.i_alu_valid || r_rr_ld);
    assign w_grant_alu = bus.i_alu_valid && !w_grant_ld;
    assign w_fmt       = fmt_load(w_head);
    assign w_clr       = (w_grant_ld && w_head.rd != '0) ? XLEN'(1) << w_head.rd : '0;
    assign w_set       = (bus.i_ld_issue && bus.i_ld_issue_rd_5 != '0) ? XLEN'(1) << bus.i_ld_issue_rd_5 : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ld <= 1'b0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_rr_ld <= w_contend ? !r_rr_ld : r_rr_ld;
            r_wen   <= (w_grant_ld && w_head.rd != '0) || (w_grant_alu && bus.i_alu_rd_5 != '0);
            if (w_grant_ld) begin
                r_waddr <= w_head.rd;
                r_wdata <= w_fmt.data;
            end else if (w_grant_alu) begin
                r_waddr <= bus.i_alu_rd_5;
                r_wdata <= bus.i_alu_data_32;
            end
            r_busy <= (r_busy & ~w_clr) | w_set;
            r_err  <= r_err || (w_grant_ld && w_fmt.err);
        end
    end
    assign bus.o_alu_ready    = w_grant_alu;
    assign bus.o_ld_ready     = !w_full;
    assign bus.o_wen          = r_wen;
    assign bus.o_waddr_5      = r_waddr;
    assign bus.o_wdata_32     = r_wdata;
    assign bus.o_busy_32      = r_busy;
    assign bus.o_misalign_err = r_err;
`ifdef WB_FWD_EN
    assign bus.o_opnd1_32 = (r_wen && r_waddr == bus.i_raddr1_5 && bus.i_raddr1_5 != '0) ? r_wdata : bus.i_rf_rdata1_32;
    assign bus.o_opnd2_32 = (r_wen && r_waddr == bus.i_raddr2_5 && bus.i_raddr2_5 != '0) ? r_wdata : bus.i_rf_rdata2_32;
`endif
`ifndef SYNTHESIS
    // Re-issuing a load to its own rd is legal only in the cycle its previous writeback clears the bit.
    a_ld_issue_busy: assert property (@(posedge clk) disable iff (rst) !(|(w_set & r_busy & ~w_clr)));
    a_alu_busy: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_alu_valid && bus.i_alu_rd_5 != '0 && r_busy[bus.i_alu_rd_5]));
`endif
endmodule
